// File: rtl/mem_pkg.sv
// Shared instruction-memory types and constants used by the loader.
package mem_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  // Length header and checksum trailer are each one little-endian word.
  localparam int LoaderLenBytes = 4;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs a little-endian byte stream into 32-bit words. word_valid and
// word_out are combinational on the 4th byte, so the consumer can register
// the finished word on the same edge that accepts its last byte.
module byte_assembler
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output word_t       word_out
);

  logic [1:0]  cnt;
  logic [23:0] part;

  assign word_valid = byte_valid && (cnt == 2'(LoaderLenBytes - 1));
  assign word_out   = {byte_in, part};

  // Byte position counter and the three lower bytes of the word in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      part <= '0;
    end else if (clear) begin
      cnt  <= '0;
    end else if (byte_valid) begin
      cnt <= cnt + 2'd1;
      case (cnt)
        2'd0:    part[7:0]   <= byte_in;
        2'd1:    part[15:8]  <= byte_in;
        2'd2:    part[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length header, N data words written from
// address 0 upward, then done/error. Build option LOADER_CHECKSUM_EN adds a
// trailing 32-bit checksum word (sum of data words) checked before DONE.
module imem_loader
  import mem_pkg::*;
#(
  parameter int MemSize = 'h0000_1000,
  localparam int MemAddrWidth = $clog2(MemSize)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    rx_ready,
  output logic                    mem_we,
  output logic [MemAddrWidth-1:0] mem_address,
  output logic [31:0]             mem_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  // Word index must reach MemSize/4 itself, hence one bit more than an index.
  localparam int WordIdxW = MemAddrWidth - 1;
  localparam logic [WordIdxW-1:0] WordOne = 1;
  localparam word_t MaxWords = word_t'(MemSize >> 2);

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_t PostData = CSUM;
`else
  localparam loader_state_t PostData = DONE;
`endif

  loader_state_t state_q, state_d;

  logic                byte_take;
  logic                word_valid;
  word_t               word_out;
  logic [WordIdxW-1:0] word_idx;
  logic [WordIdxW-1:0] len;
  logic                last_word;

`ifdef LOADER_CHECKSUM_EN
  word_t sum;
`endif

  // start has priority: a byte presented with start is dropped.
  assign byte_take = rx_valid && rx_ready && !start;
  assign last_word = (word_idx == len - WordOne);

  assign rx_ready = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign busy     = rx_ready;
  assign done     = (state_q == DONE);
  assign error    = (state_q == ERROR);

  byte_assembler u_asm (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start),
    .byte_valid (byte_take),
    .byte_in    (rx_data),
    .word_valid (word_valid),
    .word_out   (word_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (start) state_d = LEN;
        else if (word_valid) begin
          if (word_out > MaxWords)  state_d = ERROR;
          else if (word_out == '0)  state_d = PostData;
          else                      state_d = DATA;
        end
      end
      DATA: begin
        if (start) state_d = LEN;
        else if (word_valid && last_word) state_d = PostData;
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        if (start) state_d = LEN;
        else if (word_valid) state_d = (word_out == sum) ? DONE : ERROR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Length capture, word counter, memory write port and running checksum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      word_idx    <= '0;
      len         <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (start) begin
        word_idx <= '0;
        len      <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end else if (word_valid) begin
        if (state_q == LEN) begin
          len <= word_out[WordIdxW-1:0];
        end else if (state_q == DATA) begin
          mem_we      <= 1'b1;
          mem_data    <= word_out;
          mem_address <= {word_idx[WordIdxW-2:0], 2'b00};
          word_idx    <= word_idx + WordOne;
`ifdef LOADER_CHECKSUM_EN
          sum         <= sum + word_out;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default MemSize 'h1000).
// Define LOADER_CHECKSUM_EN for both RTL and bench to cover the checksum build.
module tb_imem_loader;

  localparam int MemSize = 'h1000;
  localparam int AW = $clog2(MemSize);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready, mem_we, busy, done, error;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_data;

  int n_cmp = 0;
  int n_bad = 0;

  // write log, filled by the monitor
  int          wr_cnt = 0;
  logic [31:0] wr_addr [0:4095];
  logic [31:0] wr_data [0:4095];
  int          nrdy_busy = 0;

  imem_loader #(.MemSize(MemSize)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_address(mem_address), .mem_data(mem_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // sample outputs mid-cycle
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr[wr_cnt[11:0]] <= 32'(mem_address);
      wr_data[wr_cnt[11:0]] <= mem_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (busy && !rx_ready) nrdy_busy <= nrdy_busy + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // present a byte and hold it until the edge that accepts it
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!rx_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL rx_ready_timeout: observed 0 expected 1");
    end
    tick(1);
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (max_gap > 0) begin
        rx_valid = 1'b0;
        tick($urandom_range(0, max_gap));
      end
    end
  endtask

  task automatic finish_frame(input logic [31:0] csum);
`ifdef LOADER_CHECKSUM_EN
    send_word(csum, 0);
`else
    if (csum == 32'hx) ;
`endif
    rx_valid = 1'b0;
    tick(2);
  endtask

  int base;
  logic [31:0] sum;
  logic [31:0] g_addr [0:2];

  initial begin
    // reset state
    tick(2);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_rdy",  {31'b0, rx_ready}, 0);
    reset_n = 1'b1;
    tick(1);

    // 1: two-word load
    base = wr_cnt;
    pulse_start();
    chk("t1_busy_start", {31'b0, busy}, 1);
    send_word(32'd2, 0);
    send_word(32'h00000513, 0);
    send_word(32'h0000006f, 0);
    finish_frame(32'h00000582);
    chk("t1_wcnt",  wr_cnt - base, 2);
    chk("t1_a0",    wr_addr[base], 0);
    chk("t1_d0",    wr_data[base], 32'h00000513);
    chk("t1_a1",    wr_addr[base+1], 4);
    chk("t1_d1",    wr_data[base+1], 32'h0000006f);
    chk("t1_done",  {31'b0, done}, 1);
    chk("t1_busy",  {31'b0, busy}, 0);
    chk("t1_rdy",   {31'b0, rx_ready}, 0);
    chk("t1_hold_d", mem_data, 32'h0000006f);

    // 2a: N = 1025 is too large
    base = wr_cnt;
    pulse_start();
    chk("t2a_done_clr", {31'b0, done}, 0);
    send_word(32'd1025, 0);
    rx_valid = 1'b0;
    tick(2);
    chk("t2a_err",  {31'b0, error}, 1);
    chk("t2a_busy", {31'b0, busy}, 0);
    chk("t2a_wcnt", wr_cnt - base, 0);

    // 2b: N = 1024 fills memory
    base = wr_cnt;
    sum = 0;
    pulse_start();
    chk("t2b_err_clr", {31'b0, error}, 0);
    send_word(32'd1024, 0);
    for (int i = 0; i < 1024; i++) begin
      send_word(32'h1000_0000 + 32'(i * 3), 0);
      sum = sum + 32'h1000_0000 + 32'(i * 3);
    end
    finish_frame(sum);
    chk("t2b_wcnt",  wr_cnt - base, 1024);
    chk("t2b_alast", wr_addr[base+1023], 32'hffc);
    chk("t2b_dlast", wr_data[base+1023], 32'h1000_0000 + 32'(1023 * 3));
    chk("t2b_a1",    wr_addr[base+1], 4);
    chk("t2b_done",  {31'b0, done}, 1);

    // 3: empty frame
    base = wr_cnt;
    pulse_start();
    send_word(32'd0, 0);
    finish_frame(32'd0);
    chk("t3_done", {31'b0, done}, 1);
    chk("t3_wcnt", wr_cnt - base, 0);

    // 4: gapped three-word load
    base = wr_cnt;
    pulse_start();
    send_word(32'd3, 3);
    send_word(32'h11223344, 3);
    send_word(32'h55667788, 3);
    send_word(32'h99aabbcc, 3);
    finish_frame(32'h11223344 + 32'h55667788 + 32'h99aabbcc);
    g_addr[0] = 0; g_addr[1] = 4; g_addr[2] = 8;
    chk("t4_wcnt", wr_cnt - base, 3);
    for (int i = 0; i < 3; i++) chk($sformatf("t4_a%0d", i), wr_addr[base+i], g_addr[i]);
    chk("t4_d0", wr_data[base],   32'h11223344);
    chk("t4_d1", wr_data[base+1], 32'h55667788);
    chk("t4_d2", wr_data[base+2], 32'h99aabbcc);
    chk("t4_done", {31'b0, done}, 1);
    chk("t4_nostall", nrdy_busy, 0);

    // 5: restart mid-word; the byte coincident with start is dropped
    base = wr_cnt;
    pulse_start();
    send_word(32'd1, 0);
    send_byte(8'h13);
    send_byte(8'h05);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hdeadbeef, 0);
    finish_frame(32'hdeadbeef);
    chk("t5_wcnt", wr_cnt - base, 1);
    chk("t5_a0",   wr_addr[base], 0);
    chk("t5_d0",   wr_data[base], 32'hdeadbeef);
    chk("t5_done", {31'b0, done}, 1);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch
    base = wr_cnt;
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    finish_frame(32'd3);
    chk("t6a_done", {31'b0, done}, 1);
    chk("t6a_wcnt", wr_cnt - base, 2);
    base = wr_cnt;
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'd1, 0);
    send_word(32'd2, 0);
    finish_frame(32'd4);
    chk("t6b_err",  {31'b0, error}, 1);
    chk("t6b_done", {31'b0, done}, 0);
    chk("t6b_wcnt", wr_cnt - base, 2);
`endif

    // 5b: reset mid-word clears every output on the next edge
    base = wr_cnt;
    pulse_start();
    send_word(32'd2, 0);
    send_word(32'hcafef00d, 0);
    send_byte(8'h01);
    send_byte(8'h02);
    rx_valid = 1'b0;
    chk("t5b_wcnt", wr_cnt - base, 1);
    reset_n = 1'b0;
    tick(1);
    chk("t5b_busy", {31'b0, busy}, 0);
    chk("t5b_rdy",  {31'b0, rx_ready}, 0);
    chk("t5b_flags", {30'b0, done, error}, 0);
    chk("t5b_we",   {31'b0, mem_we}, 0);
    chk("t5b_addr", 32'(mem_address), 0);
    chk("t5b_data", mem_data, 0);
    reset_n = 1'b1;
    tick(2);
    chk("t5b_idle", {31'b0, busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
